// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson (twisted-ring) counter and its bench.
package johnson_pkg;

   localparam int MAX_W = 32;
   localparam logic [MAX_W:0] ONE = (MAX_W+1)'(1);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

   function automatic int idx_w(input int width);
      return $clog2(2 * width);
   endfunction

   // Legal codes are one contiguous run of ones touching bit 0 or the MSB of a
   // width-bit ring; v&(v+1)==0 tests "ones only from the bottom up".
   function automatic logic is_legal(input logic [MAX_W-1:0] q, input int width);
      logic [MAX_W:0] mask;
      logic [MAX_W:0] v;
      logic [MAX_W:0] inv;
      mask = (ONE << width) - ONE;
      v    = {1'b0, q} & mask;
      inv  = ~v & mask;
      return ((v & (v + ONE)) == '0) || ((inv & (inv + ONE)) == '0);
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational ring-state decoder: q -> state index and illegal-code flag.
module johnson_decode
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDXW  = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] q,
   output logic [IDXW-1:0]  idx,
   output logic             err
);

   int pc;

   // First half of the sequence fills from bit 0, second half drains from bit 0.
   always_comb begin
      pc = 0;
      for (int i = 0; i < WIDTH; i++) begin
         pc = pc + {31'b0, q[i]};
      end
      if (q == '0 || q[0]) begin
         idx = IDXW'(pc);
      end else begin
         idx = IDXW'(2 * WIDTH - pc);
      end
      err = !is_legal(MAX_W'(q), WIDTH);
   end

endmodule

// File: rtl/johnson_counter.sv
// Johnson counter with enable, direction and parallel load; wrap pulse on sequence wrap.
// Optional JOHNSON_SELF_CORRECT_EN: illegal codes are forced back to zero on the next edge.
module johnson_counter
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDXW  = idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [IDXW-1:0]  idx,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] LAST_CODE = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             dec_err;

   johnson_decode #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_decode (
      .q   (q),
      .idx (idx),
      .err (dec_err)
   );

   // Wrap is keyed on the single code that precedes the wrap in each direction.
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      if (load) begin
         q_nxt = load_val;
`ifdef JOHNSON_SELF_CORRECT_EN
      end else if (dec_err) begin
         q_nxt = '0;
`endif
      end else if (en) begin
         if (dir_e'(dir) == DIR_DOWN) begin
            q_nxt    = {~q[0], q[WIDTH-1:1]};
            wrap_nxt = (q == '0);
         end else begin
            q_nxt    = {q[WIDTH-2:0], ~q[WIDTH-1]};
            wrap_nxt = (q == LAST_CODE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
      end
   end

`ifdef JOHNSON_SELF_CORRECT_EN
   assign err = dec_err;
`else
   logic unused_dec_err;
   assign unused_dec_err = dec_err;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_counter.sv
// Directed table-driven bench for johnson_counter (WIDTH=4), both build variants.
module tb_johnson_counter;
   import johnson_pkg::*;

   localparam int W    = 4;
   localparam int IDXW = idx_w(W);
`ifdef JOHNSON_SELF_CORRECT_EN
   localparam logic SC = 1'b1;
`else
   localparam logic SC = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic            dir;
   logic            load;
   logic [W-1:0]    load_val;
   logic [W-1:0]    q;
   logic [IDXW-1:0] idx;
   logic            wrap;
   logic            err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         rst_n;
      logic         en;
      logic         dir;
      logic         load;
      logic [W-1:0] lv;
      logic [W-1:0] eq;
      int           eidx;   // -1: index is don't-care
      logic         ew;
      logic         ee;
   } vec_t;

   vec_t vecs[$];

   johnson_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .idx      (idx),
      .wrap     (wrap),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic e, input logic d, input logic l,
                               input logic [W-1:0] lv, input logic [W-1:0] eq, input int eidx,
                               input logic ew, input logic ee);
      vec_t v;
      v.rst_n = r; v.en = e; v.dir = d; v.load = l; v.lv = lv;
      v.eq = eq; v.eidx = eidx; v.ew = ew; v.ee = ee;
      vecs.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      reset = v.rst_n; en = v.en; dir = v.dir; load = v.load; load_val = v.lv;
   endtask

   initial begin
      logic [W-1:0] seq [8];
      seq[0] = 4'b0000; seq[1] = 4'b0001; seq[2] = 4'b0011; seq[3] = 4'b0111;
      seq[4] = 4'b1111; seq[5] = 4'b1110; seq[6] = 4'b1100; seq[7] = 4'b1000;

      //   rst en dir ld  lv       q        idx wrap err
      add(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0011, 2, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0111, 3, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b1111, 4, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b1110, 5, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b1100, 6, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b1000, 7, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0011, 2, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0111, 3, 0, 0);
      // reverse at idx 3
      add(1, 1, 1, 0, 4'b0000, 4'b0011, 2, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b0001, 1, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b1000, 7, 1, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b1100, 6, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b1110, 5, 0, 0);
      // hold
      for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 4'b0000, 4'b1110, 5, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b1100, 6, 0, 0);
      // load beats en/dir
      add(1, 1, 1, 1, 4'b1111, 4'b1111, 4, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b0111, 3, 0, 0);
      // illegal load
      add(1, 0, 0, 1, 4'b0101, 4'b0101, -1, 0, SC);
`ifdef JOHNSON_SELF_CORRECT_EN
      add(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
`else
      add(1, 1, 0, 0, 4'b0000, 4'b1011, -1, 0, 0);
`endif
      add(1, 1, 0, 1, 4'b1100, 4'b1100, 6, 0, 0);
      // reset mid-count wins over en and load
      add(0, 1, 0, 1, 4'b1111, 4'b0000, 0, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
      // load onto the wrap boundary never pulses wrap
      add(1, 0, 0, 1, 4'b1000, 4'b1000, 7, 0, 0);
      add(1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 1, 1, 0, 4'b0000, 4'b1000, 7, 1, 0);
      add(1, 0, 1, 0, 4'b0000, 4'b1000, 7, 0, 0);

      drive(vecs[0]);
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk("q", i, 32'(q), 32'(vecs[i].eq));
         if (vecs[i].eidx >= 0) chk("idx", i, 32'(idx), 32'(vecs[i].eidx));
         chk("wrap", i, 32'(wrap), 32'(vecs[i].ew));
         chk("err", i, 32'(err), 32'(vecs[i].ee));
      end

      // Load every code: legal ones must decode to their sequence position.
      for (int v = 0; v < 16; v++) begin
         int pos;
         logic [W-1:0] lv;
         lv = W'(v);
         pos = -1;
         for (int k = 0; k < 8; k++) if (seq[k] == lv) pos = k;
         reset = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b1; load_val = lv;
         @(posedge clk);
         #1;
         chk("ld_q", v, 32'(q), 32'(lv));
         chk("ld_wrap", v, 32'(wrap), 32'd0);
         chk("ld_err", v, 32'(err), 32'(SC & (pos < 0)));
         chk("legal_fn", v, 32'(is_legal(32'(lv), W)), 32'(pos >= 0));
         if (pos >= 0) chk("ld_idx", v, 32'(idx), 32'(pos));
      end

      // Wrap pulse lasts exactly one cycle across a full up lap.
      begin
         int pulses;
         pulses = 0;
         reset = 1'b0; load = 1'b0; en = 1'b0;
         @(posedge clk);
         #1;
         reset = 1'b1; en = 1'b1; dir = 1'b0;
         for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (wrap) pulses++;
            chk("lap_idx", c, 32'(idx), 32'((c + 1) % 8));
         end
         chk("lap_pulses", 0, 32'(pulses), 32'd2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/johnson_counter.md
Name: johnson_counter

Overview:
- Parameterised Johnson (twisted-ring) counter: WIDTH-bit shift register whose feedback is the inverted outgoing bit, cycling through 2*WIDTH states.
- Provides the raw ring value, a binary state index, and a wrap pulse.
- Used as a glitch-free phase/sequence generator (one bit changes per step) for control timing in the datapath.
- Supports enable, direction and parallel load.

Parameters:
- WIDTH, 4, ring length in bits (>=2); sequence length = 2*WIDTH
- IDXW, $clog2(2*WIDTH), width of state index output (derived; not to be overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
- en  input  1  advance enable; counter holds when 0
- dir  input  1  0 = count up (shift left), 1 = count down (shift right)
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value written to q on load (may be illegal)
- q  output  WIDTH  registered ring state
- idx  output  IDXW  combinational index 0..2*WIDTH-1 of q
- wrap  output  1  registered one-cycle pulse on sequence wrap
- err  output  1  combinational: q is not one of the 2*WIDTH legal codes

Behaviour:
- Everything is updated on the rising clk edge. Priority: reset > load > (self-correct, if enabled) > en > hold.
- Reset (reset==0 at edge): q=0, wrap=0. Resulting idx=0, err=0.
- Up step (en=1, dir=0): q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000, then 0000.
- Down step (en=1, dir=1): q <= {~q[0], q[WIDTH-1:1]}. Exact reverse of the up sequence (0000 -> 1000).
- Hold (en=0, load=0): q unchanged; wrap=0.
- Load: q <= load_val, regardless of en or dir. Load never asserts wrap.
- idx:
  - If q==0 or q[0]==1: idx = popcount(q).
  - Otherwise: idx = 2*WIDTH - popcount(q).
  - Value is undefined (don't care) when err=1.
- wrap:
  - Asserted for exactly one cycle after an enabled step from idx 2*WIDTH-1 to 0 (up) or from 0 to 2*WIDTH-1 (down).
  - 0 in all other cycles, including the cycle after reset or load.
- Legal code: a single contiguous run of ones anchored at bit 0 or bit WIDTH-1 (includes all-0 and all-1). err=1 for any other q.
- Direction change mid-sequence: takes effect on the next enabled edge, with no skipped or repeated state.
- Reset asserted mid-count: q returns to 0 on that edge, independent of en and load.

Optional Feature:
- Macro: JOHNSON_SELF_CORRECT_EN.
- Defined:
  - When err=1 and load=0, the next rising edge forces q <= 0, regardless of en. wrap stays 0.
  - err is asserted for that cycle.
- Undefined:
  - No correction. Illegal codes shift with the same rules as legal codes, so an illegal sequence circulates indefinitely.
  - err is tied to 0.

Decomposition:
- Package johnson_pkg holds:
  - localparam function for IDXW
  - typedef enum dir_e {DIR_UP=0, DIR_DOWN=1}
  - a function is_legal(q) shared by RTL and bench.
- One natural sub-module: johnson_decode (combinational q -> idx, err), reusable by the bench reference model.

Test Plan:
- Reset low 1 cycle, then en=1, dir=0 for 10 cycles (WIDTH=4) -> q = 0000,0001,0011,0111,1111,1110,1100,1000,0000,0001. idx = 0..7,0,1. wrap=1 only in the cycle q returns to 0000.
- From q=0111 (idx 3), set dir=1 for 4 cycles -> q = 0011,0001,0000,1000. wrap=1 in the cycle q becomes 1000.
- en=0 for 5 cycles at q=1110 -> q stays 1110, wrap=0. Then en=1 -> q=1100.
- load=1, load_val=1111, with en=1, dir=1 -> q=1111, idx=4, wrap=0. Next down step -> q=0111.
- load_val=0101 (illegal) -> err=1. With JOHNSON_SELF_CORRECT_EN: next edge gives q=0000 even with en=0. Without the macro: err=0, and an up step gives q=1011.
- reset=0 while en=1 at q=1100 -> q=0000, wrap=0 on that edge. Releasing reset resumes the count from 0001.
